pong_match_ctrl: RTL



---
 rtl/pong_match_ctrl.sv | 128 ++++++++++++
 1 files changed

// File: rtl/pong_match_ctrl.sv
// rtl/pong_match_ctrl.sv - ping-pong match sequencer: game FSM, scores, win decision
// Gates the ball engine (run/restart/serve direction) and consumes per-point pulses.
module pong_match_ctrl #(
  parameter int WIN_SCORE   = 9,
  parameter int SERVE_DELAY = 60,
  parameter int OVER_HOLD   = 300
) (
  input  logic       slowclock,
  input  logic       reset,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       point_p1,
  input  logic       point_p2,
  output logic       ball_run,
  output logic       ball_restart,
  output logic       serve_dir,
  output logic [3:0] score1,
  output logic [3:0] score2,
  output logic [1:0] winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_PAUSE = 3'd3,
    S_OVER  = 3'd4
  } state_t;

  localparam int MAX_CNT = (SERVE_DELAY > OVER_HOLD) ? SERVE_DELAY : OVER_HOLD;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam logic [3:0]    WIN      = 4'(WIN_SCORE);
  localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_DELAY - 1);
  localparam logic [CW-1:0] OVER_LAST  = CW'(OVER_HOLD - 1);

  state_t        r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic          r_start_q, r_pause_q;
  logic          r_ball_run, r_ball_restart, r_serve_dir;
  logic [3:0]    r_score1, r_score2;
  logic [1:0]    r_winner;

  logic          w_start_rise, w_pause_rise, w_p1_only, w_p2_only, w_both;
  logic [3:0]    w_s1_inc, w_s2_inc;

  assign w_start_rise = start_btn & ~r_start_q;
  assign w_pause_rise = pause_btn & ~r_pause_q;
  assign w_p1_only    = point_p1 & ~point_p2;
  assign w_p2_only    = point_p2 & ~point_p1;
  assign w_both       = point_p1 & point_p2;
  // Saturating increments; reaching WIN ends the match so wrap cannot happen.
  assign w_s1_inc     = (r_score1 < WIN) ? r_score1 + 4'd1 : r_score1;
  assign w_s2_inc     = (r_score2 < WIN) ? r_score2 + 4'd1 : r_score2;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_rise) w_next = S_SERVE;
      S_SERVE: if (r_cnt == SERVE_LAST) w_next = S_PLAY;
      S_PLAY: begin
        if (w_both)            w_next = S_SERVE;
        else if (w_p1_only)    w_next = (w_s1_inc == WIN) ? S_OVER : S_SERVE;
        else if (w_p2_only)    w_next = (w_s2_inc == WIN) ? S_OVER : S_SERVE;
        else if (w_pause_rise) w_next = S_PAUSE;
      end
      S_PAUSE: if (w_pause_rise) w_next = S_PLAY;
      S_OVER:  if (r_cnt == OVER_LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge slowclock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Outputs are derived from the next state so they line up with the new state.
  always_ff @(posedge slowclock) begin
    if (reset) begin
      r_cnt          <= '0;
      r_start_q      <= 1'b0;
      r_pause_q      <= 1'b0;
      r_ball_run     <= 1'b0;
      r_ball_restart <= 1'b0;
      r_serve_dir    <= 1'b0;
      r_score1       <= 4'd0;
      r_score2       <= 4'd0;
      r_winner       <= 2'b00;
    end else begin
      r_start_q      <= start_btn;
      r_pause_q      <= pause_btn;
      r_ball_run     <= (w_next == S_PLAY);
      r_ball_restart <= (w_next == S_SERVE) && (r_state != S_SERVE);
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (r_state == S_SERVE || r_state == S_OVER) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (r_state == S_IDLE && w_start_rise) begin
        r_score1    <= 4'd0;
        r_score2    <= 4'd0;
        r_winner    <= 2'b00;
        r_serve_dir <= 1'b0;
      end else if (r_state == S_PLAY && w_p1_only) begin
        r_score1    <= w_s1_inc;
        r_serve_dir <= 1'b0;
        if (w_s1_inc == WIN) r_winner <= 2'b01;
      end else if (r_state == S_PLAY && w_p2_only) begin
        r_score2    <= w_s2_inc;
        r_serve_dir <= 1'b1;
        if (w_s2_inc == WIN) r_winner <= 2'b10;
      end
    end
  end

  assign ball_run     = r_ball_run;
  assign ball_restart = r_ball_restart;
  assign serve_dir    = r_serve_dir;
  assign score1       = r_score1;
  assign score2       = r_score2;
  assign winner       = r_winner;
  assign state        = r_state;

endmodule
